ecc_secded_enc_64x8: RTL

//  Pipelined SECDED (72,64) Hamming encoder. Computes 8 check bits for 64-bit RAM write data.

---
 rtl/ecc_secded_pkg.sv | 45 ++++
 rtl/ecc_pipe_stage.sv | 31 +++
 rtl/ecc_secded_enc_64x8.sv | 99 +++++++++
 3 files changed

// File: rtl/ecc_secded_pkg.sv
// Shared constants and code-definition helpers for the (72,64) SECDED encoder.
package ecc_secded_pkg;

    localparam int DATA_W = 64;
    localparam int CHK_W  = 8;
    localparam int POS_W  = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CHK_W-1:0]  chk_t;

    typedef struct packed {
        logic dbit;
        logic sbit;
    } inj_t;

    // Data bits fill the non-power-of-two codeword positions 3,5,6,7,9,... in ascending order.
    function automatic logic [POS_W-1:0] data_pos(input int i);
        int n;
        logic [POS_W-1:0] p;
        n = 0;
        p = '0;
        for (int pos = 1; pos < 72; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == i) p = POS_W'(pos);
                n++;
            end
        end
        return p;
    endfunction

    function automatic chk_t secded_chk(input data_t d);
        chk_t c;
        logic [POS_W-1:0] p;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            p = data_pos(i);
            for (int k = 0; k < POS_W; k++) begin
                if (p[k]) c[k] = c[k] ^ d[i];
            end
        end
        c[CHK_W-1] = (^d) ^ (^c[CHK_W-2:0]);
        return c;
    endfunction

endpackage

// File: rtl/ecc_pipe_stage.sv
// One valid/ready pipeline register; accepts when empty or when its contents leave this cycle.
module ecc_pipe_stage
    import ecc_secded_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    assign in_rdy = en & rst_n & (~out_vld | out_rdy);

    // Payload only loads with a real beat, so idle X on the input never reaches the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) out_data <= in_data;
        end
    end

endmodule

// File: rtl/ecc_secded_enc_64x8.sv
// Pipelined (72,64) SECDED encoder for the RAM write path, with optional error injection
// applied to the data after the check bits are formed.
module ecc_secded_enc_64x8
    import ecc_secded_pkg::*;
#(
    parameter int REG_INPUT = 1,
    parameter int INJ_EN    = 1,
    parameter int CNT_W     = 32
) (
    input  logic              ecc_clk,
    input  logic              ecc_reset_n,
    input  logic              ecc_clken,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_sbit,
    input  logic              inj_dbit,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_chkbits,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int A_W = DATA_W + 2;
    localparam int B_W = DATA_W + CHK_W;

    inj_t           inj_in;
    inj_t           inj_p0;
    logic [A_W-1:0] pay_in;
    logic [A_W-1:0] pay_p0;
    logic           vld_p0;
    logic           rdy_p0;
    data_t          data_p0;
    data_t          data_inj;
    chk_t           chk_p0;
    logic [B_W-1:0] pay_b;
    logic [B_W-1:0] pay_p1;
    logic           vld_p1;

    assign inj_in.sbit = (INJ_EN != 0) & inj_sbit;
    assign inj_in.dbit = (INJ_EN != 0) & inj_dbit;
    assign pay_in      = {inj_in, in_data};

    // ---- stage p0: optional input register ----
    generate
        if (REG_INPUT != 0) begin : g_reg_in
            ecc_pipe_stage #(.W(A_W)) u_stage_a (
                .clk      (ecc_clk),
                .rst_n    (ecc_reset_n),
                .en       (ecc_clken),
                .in_vld   (in_vld),
                .in_rdy   (in_rdy),
                .in_data  (pay_in),
                .out_vld  (vld_p0),
                .out_rdy  (rdy_p0),
                .out_data (pay_p0)
            );
        end else begin : g_no_reg_in
            assign vld_p0 = in_vld;
            assign pay_p0 = pay_in;
            assign in_rdy = rdy_p0;
        end
    endgenerate

    // ---- parity tree and injection between p0 and p1 ----
    always_comb begin
        data_p0  = pay_p0[DATA_W-1:0];
        inj_p0   = pay_p0[A_W-1:DATA_W];
        chk_p0   = secded_chk(data_p0);
        data_inj = data_p0;
        if (inj_p0.dbit)      data_inj[1:0] = data_p0[1:0] ^ 2'b11;
        else if (inj_p0.sbit) data_inj[0]   = ~data_p0[0];
        pay_b    = {chk_p0, data_inj};
    end

    // ---- stage p1: output register ----
    ecc_pipe_stage #(.W(B_W)) u_stage_b (
        .clk      (ecc_clk),
        .rst_n    (ecc_reset_n),
        .en       (ecc_clken),
        .in_vld   (vld_p0),
        .in_rdy   (rdy_p0),
        .in_data  (pay_b),
        .out_vld  (vld_p1),
        .out_rdy  (out_rdy),
        .out_data (pay_p1)
    );

    assign out_vld     = vld_p1;
    assign out_data    = pay_p1[DATA_W-1:0];
    assign out_chkbits = pay_p1[B_W-1:DATA_W];

    always_ff @(posedge ecc_clk or negedge ecc_reset_n) begin
        if (!ecc_reset_n)                      beat_cnt <= '0;
        else if (vld_p1 & out_rdy & ecc_clken) beat_cnt <= beat_cnt + CNT_W'(1);
    end

endmodule
